// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard / stall controller with multi-cycle load latency, memory-busy freeze and branch flush.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_stall_ctrl #(
  parameter int REG_W    = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_RS,
  input  logic [REG_W-1:0] ID_RT,
  input  logic             ID_Use_RS,
  input  logic             ID_Use_RT,
  input  logic [REG_W-1:0] EX_RT,
  input  logic             EX_Mem_Read,
  input  logic             MEM_Busy,
  input  logic             EX_Branch_Taken,
  output logic             is_stall,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFID_Flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE   = 1'b0,
    LSTALL = 1'b1
  } state_t;

  localparam logic [3:0] LAT_RELOAD = 4'(LOAD_LAT - 1);

  state_t     state;
  logic [3:0] cnt;

  logic hit;
  logic flush_c;
  logic stall_c;

  assign hit = EX_Mem_Read &
               ((ID_Use_RS & (EX_RT == ID_RS)) | (ID_Use_RT & (EX_RT == ID_RT)));

  // Priority: reset > MEM_Busy > branch flush > LSTALL > hit.
  assign flush_c = !reset && !MEM_Busy && EX_Branch_Taken;
  assign stall_c = !reset && !MEM_Busy && !EX_Branch_Taken &&
                   ((state == LSTALL) || hit);

  assign is_stall   = flush_c | stall_c;
  assign PCWrite    = !(MEM_Busy && !reset) && !stall_c;
  assign IFIDWrite  = !(MEM_Busy && !reset) && !stall_c;
  assign IFID_Flush = flush_c;
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else if (MEM_Busy) begin
      state <= state;
      cnt   <= cnt;
    end else if (EX_Branch_Taken) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else if (state == LSTALL) begin
      if (cnt == 4'd1) begin
        state <= IDLE;
        cnt   <= 4'd0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end else if (hit && (LOAD_LAT > 1)) begin
      state <= LSTALL;
      cnt   <= LAT_RELOAD;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Saturating counters; a flush cycle is not counted as a stall cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_c && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + 1'b1;
      if (flush_c && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
